halton_stream_sched: RTL and testbench
======================================

HALTON_STREAM_SCHED -- requirements
Module: halton_stream_sched

Interface
REQ-001 SHALL have parameter SEQWIDTH, default 8, giving the bit width of the sequence, source values and burst length.
REQ-002 SHALL have parameter NREQ, default 4, giving the number of requesters; legal values are 2 to 8.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req, input, NREQ bits: per-requester burst request.
REQ-006 SHALL have port src, input, NREQ x SEQWIDTH bits: per-requester unsigned source value.
REQ-007 SHALL have port len, input, SEQWIDTH bits: burst length minus 1, sampled at grant.
REQ-008 SHALL have port gnt, output, NREQ bits: one-hot grant, held for the whole burst.
REQ-009 SHALL have port out_bit, output, 1 bit: stochastic bit for the current sequence value.
REQ-010 SHALL have port out_valid, output, 1 bit: out_bit is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts out_bit.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse after the last bit of a burst is accepted.

Function
REQ-013 SHALL implement states IDLE, RUN and DONE.
REQ-014 SHALL keep an internal SEQWIDTH-bit counter cnt; the sequence value seq SHALL be cnt bit-reversed, which is the base-2 Halton sequence.
REQ-015 In IDLE with any req bit high, SHALL select the winner by round-robin, starting from the index after the last granted requester (index 0 after reset).
REQ-016 SHALL latch the winner's src into src_q and len into len_q, assert gnt on the next cycle and enter RUN; IDLE-to-gnt latency is 1 cycle.
REQ-017 In RUN, SHALL drive out_valid=1 and out_bit=(src_q > seq), unsigned strict compare.
REQ-018 In RUN, on out_valid && out_ready, SHALL increment cnt (wrapping modulo 2^SEQWIDTH) and increment the burst count bcnt.
REQ-019 While out_ready=0, SHALL hold out_bit, seq, cnt and bcnt unchanged.
REQ-020 When a handshake occurs with bcnt==len_q, SHALL enter DONE.
REQ-021 In DONE, SHALL assert done for exactly one cycle, deassert gnt and out_valid, then return to IDLE.
REQ-022 The earliest next grant SHALL be the cycle after DONE; a burst is never preempted.
REQ-023 In RUN, changes to req, src and len SHALL be ignored, including the granted requester dropping req.
REQ-024 With no req in IDLE, SHALL stay in IDLE with outputs at their reset values.

Reset
REQ-025 When rst=0, SHALL asynchronously enter IDLE with gnt=0, out_valid=0, out_bit=0, done=0, cnt=0, bcnt=0, and round-robin pointer on requester 0.
REQ-026 Reset mid-burst SHALL abort the burst with no done pulse; the first grant after reset SHALL follow REQ-015 with pointer 0.

Configuration
REQ-027 With HALTON_RESTART_EN defined, SHALL clear cnt to 0 at every grant, so each burst starts at seq=0.
REQ-028 Without HALTON_RESTART_EN, cnt SHALL continue across bursts and only reset clears it.

Verification
REQ-029 Single requester, SEQWIDTH=8: req=0001, src[0]=128, len=255, out_ready=1 -> gnt=0001; 256 valid bits with exactly 128 ones; done pulse; return to IDLE.
REQ-030 Compare extremes: src=0 -> 0 ones over 256 bits; src=255 -> 255 ones over 256 bits.
REQ-031 Short burst with HALTON_RESTART_EN: src=128, len=3 -> seq 0,128,64,192, out_bit 1,0,1,0; second identical burst -> same 1,0,1,0; without the macro, second burst -> seq 32,160,96,224, out_bit 1,0,1,0.
REQ-032 Round-robin: req=1111 held -> grant order 0,1,2,3,0; with req=1010 -> order 1,3,1.
REQ-033 Backpressure: out_ready=0 for 5 cycles mid-burst -> out_bit and seq frozen, no count advance; burst still yields exactly len+1 accepted bits.
REQ-034 Reset mid-burst: rst=0 at bit 10 -> gnt=0, out_valid=0, no done; after release, req=0100 -> gnt=0100, seq restarts at 0.

Source files
------------

// File: rtl/halton_stream_sched.sv
// Halton stream scheduler: round-robin grants a requester, then streams src_q > bitrev(cnt) as stochastic bits.
// Latency: grant and first valid bit 1 cycle after req is seen in IDLE; done pulses 1 cycle after the last accepted bit.
// Backpressure: out_ready=0 freezes out_bit, cnt and burst count; optional HALTON_RESTART_EN restarts cnt at every grant.
module halton_stream_sched #(
  parameter int SEQWIDTH = 8,
  parameter int NREQ     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*SEQWIDTH-1:0] src,
  input  logic [SEQWIDTH-1:0]      len,
  output logic [NREQ-1:0]          gnt,
  output logic                     out_bit,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     done
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic [PW-1:0]         r_ptr;
  logic [NREQ-1:0]       r_gnt;
  logic                  r_out_bit;
  logic                  r_out_valid;
  logic                  r_done;
  logic [SEQWIDTH-1:0]   r_cnt;
  logic [SEQWIDTH-1:0]   r_bcnt;
  logic [SEQWIDTH-1:0]   r_src_q;
  logic [SEQWIDTH-1:0]   r_len_q;

  logic                  w_any;
  logic [PW-1:0]         w_win;
  logic [NREQ-1:0]       w_win_oh;
  logic [SEQWIDTH-1:0]   w_win_src;
  logic [PW-1:0]         w_ptr_nxt;
  logic [SEQWIDTH-1:0]   w_cnt_start;
  logic [SEQWIDTH-1:0]   w_cnt_inc;
  logic [SEQWIDTH-1:0]   w_seq_start;
  logic [SEQWIDTH-1:0]   w_seq_inc;

  // Base-2 Halton value: the counter with its bit order mirrored.
  function automatic logic [SEQWIDTH-1:0] bitrev(input logic [SEQWIDTH-1:0] v);
    logic [SEQWIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < SEQWIDTH; i++) begin
      r[i] = v[SEQWIDTH-1-i];
    end
    return r;
  endfunction

  // Requester index 'off' positions after the round-robin pointer, wrapped to NREQ.
  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] p, input int off);
    int s;
    s = int'(p) + off;
    if (s >= NREQ) begin
      s = s - NREQ;
    end
    return PW'(s);
  endfunction

  // Round-robin winner search starting at the pointer, plus its one-hot and source value.
  always_comb begin
    w_any     = 1'b0;
    w_win     = '0;
    w_win_oh  = '0;
    w_win_src = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_any && req[rr_idx(r_ptr, i)]) begin
        w_any = 1'b1;
        w_win = rr_idx(r_ptr, i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (PW'(i) == w_win) begin
        w_win_oh[i] = 1'b1;
        w_win_src   = src[i*SEQWIDTH +: SEQWIDTH];
      end
    end
  end

  // Pointer moves to the requester after the winner so the next search starts there.
  assign w_ptr_nxt = (w_win == PW'(NREQ - 1)) ? '0 : w_win + 1'b1;

`ifdef HALTON_RESTART_EN
  // Each burst begins at sequence value 0.
  assign w_cnt_start = '0;
`else
  // The sequence carries on from where the previous burst stopped.
  assign w_cnt_start = r_cnt;
`endif

  assign w_cnt_inc   = r_cnt + 1'b1;
  assign w_seq_start = bitrev(w_cnt_start);
  assign w_seq_inc   = bitrev(w_cnt_inc);

  // Scheduler FSM: grant in IDLE, stream bits in RUN, single-cycle done pulse in DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_out_bit   <= 1'b0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      r_cnt       <= '0;
      r_bcnt      <= '0;
      r_src_q     <= '0;
      r_len_q     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state     <= S_RUN;
            r_gnt       <= w_win_oh;
            r_ptr       <= w_ptr_nxt;
            r_src_q     <= w_win_src;
            r_len_q     <= len;
            r_bcnt      <= '0;
            r_cnt       <= w_cnt_start;
            r_out_valid <= 1'b1;
            // First bit is compared against the value the burst starts on.
            r_out_bit   <= (w_win_src > w_seq_start);
          end
        end
        S_RUN: begin
          // out_valid is always high here, so out_ready alone marks a handshake.
          if (out_ready) begin
            r_cnt <= w_cnt_inc;
            if (r_bcnt == r_len_q) begin
              r_state     <= S_DONE;
              r_done      <= 1'b1;
              r_gnt       <= '0;
              r_out_valid <= 1'b0;
              r_out_bit   <= 1'b0;
              r_bcnt      <= '0;
            end else begin
              r_bcnt    <= r_bcnt + 1'b1;
              r_out_bit <= (r_src_q > w_seq_inc);
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign out_bit   = r_out_bit;
  assign out_valid = r_out_valid;
  assign done      = r_done;

endmodule

// File: tb/tb_halton_stream_sched.sv
// Scoreboard bench for halton_stream_sched: a queue-based reference model predicts every accepted bit.
// Stimulus runs at the falling edge, out_ready changes 1 time unit later, the monitor samples 3 units later.
// Directed cases cover full-period bursts, short bursts, round-robin order, backpressure and mid-burst reset.
module tb_halton_stream_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] src;
  logic [7:0]  len;
  logic [3:0]  gnt;
  logic        out_bit;
  logic        out_valid;
  logic        out_ready;
  logic        done;

  halton_stream_sched #(.SEQWIDTH(8), .NREQ(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .src       (src),
    .len       (len),
    .gnt       (gnt),
    .out_bit   (out_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .done      (done)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] g;
    logic       b;
    logic       last;
  } exp_t;

  exp_t        q[$];
  int          n_pass;
  int          n_total;
  int          m_cnt;
  int          m_ptr;
  bit          pend_done;
  int          burst_bits;
  int          burst_ones;
  logic [7:0]  obs_bits;
  bit          stall;
  bit          rdy_rand;
  logic [31:0] rnd;
  int          win;
  int          hold_bits;
  logic        hold_bit;
  int          rr_a[5];
  int          rr_b[3];

  task automatic chk(input string name, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
  endtask

  // Mirror the bits of an 8-bit counter value.
  function automatic int brev8(input int v);
    int r;
    r = 0;
    for (int b = 0; b < 8; b++) begin
      if (((v >> b) & 1) != 0) r += (1 << (7 - b));
    end
    return r;
  endfunction

  // Reference model: pick the winner and queue every bit the burst must produce.
  task automatic predict(input logic [3:0] reqv, input logic [31:0] srcv, input int lenv, output int w);
    exp_t e;
    int   sv;
    w = -1;
    for (int i = 0; i < 4; i++) begin
      int idx;
      idx = (m_ptr + i) % 4;
      if (w < 0 && reqv[idx]) w = idx;
    end
    if (w >= 0) begin
      m_ptr = (w + 1) % 4;
`ifdef HALTON_RESTART_EN
      m_cnt = 0;
`endif
      sv = int'((srcv >> (8 * w)) & 32'hFF);
      for (int k = 0; k <= lenv; k++) begin
        e.g    = 4'(1 << w);
        e.b    = (sv > brev8(m_cnt));
        e.last = (k == lenv);
        q.push_back(e);
        m_cnt = (m_cnt + 1) % 256;
      end
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        if (pend_done) begin
          chk("done_pulse", int'(done), 1);
          pend_done = 0;
        end
        if (out_valid && out_ready) begin
          burst_bits++;
          burst_ones += int'(out_bit);
          obs_bits = {obs_bits[6:0], out_bit};
          if (q.size() == 0) begin
            chk("unexpected_bit", 1, 0);
          end else begin
            e = q.pop_front();
            chk("out_bit", int'(out_bit), int'(e.b));
            chk("gnt_hold", int'(gnt), int'(e.g));
            chk("done_in_run", int'(done), 0);
            if (e.last) pend_done = 1;
          end
        end
      end
    end
  endtask

  task automatic ready_drv();
    forever begin
      @(negedge clk);
      #1;
      if (stall) out_ready = 1'b0;
      else if (rdy_rand) out_ready = ($urandom_range(3) != 0);
      else out_ready = 1'b1;
    end
  endtask

  // Present a request at a falling edge with the DUT idle and check the 1-cycle grant.
  task automatic start_burst(input logic [3:0] reqv, input logic [31:0] srcv, input int lenv, output int w);
    int pw;
    req = reqv;
    src = srcv;
    len = lenv[7:0];
    burst_bits = 0;
    burst_ones = 0;
    predict(reqv, srcv, lenv, pw);
    @(negedge clk);
    chk("gnt_latency", int'(gnt), (pw >= 0) ? (1 << pw) : 0);
    chk("valid_on_grant", int'(out_valid), 1);
    w = -1;
    for (int i = 0; i < 4; i++) if (gnt[i]) w = i;
  endtask

  // Wait for done (bounded), check the burst length, and step into IDLE.
  task automatic finish_burst(input int lenv, input bit scramble);
    int t;
    if (scramble) begin
      rnd = $urandom; req = rnd[3:0];
      rnd = $urandom; src = rnd;
      rnd = $urandom; len = rnd[7:0];
    end
    t = 0;
    while (!done && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", int'(done), 1);
    chk("burst_len", burst_bits, lenv + 1);
    @(negedge clk);
  endtask

  task automatic run_burst(input logic [3:0] reqv, input logic [31:0] srcv, input int lenv,
                           input bit scramble, output int w);
    start_burst(reqv, srcv, lenv, w);
    finish_burst(lenv, scramble);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = 4'd0;
    q.delete();
    pend_done = 0;
    m_cnt = 0;
    m_ptr = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    n_pass = 0; n_total = 0; m_cnt = 0; m_ptr = 0; pend_done = 0;
    burst_bits = 0; burst_ones = 0; obs_bits = '0;
    stall = 0; rdy_rand = 0;
    rst = 1'b0; req = 4'd0; src = '0; len = '0; out_ready = 1'b1;
    rr_a = '{0, 1, 2, 3, 0};
    rr_b = '{1, 3, 1};
    fork
      monitor();
      ready_drv();
    join_none

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_bit", int'(out_bit), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b1;

    // No request: stay idle
    repeat (3) begin
      @(negedge clk);
      chk("idle_gnt", int'(gnt), 0);
      chk("idle_valid", int'(out_valid), 0);
    end

    // Full-period bursts: ones count equals src
    run_burst(4'b0001, 32'd128, 255, 0, win);
    chk("single_winner", win, 0);
    chk("ones_128", burst_ones, 128);
    run_burst(4'b0001, 32'd0, 255, 0, win);
    chk("ones_src0", burst_ones, 0);
    run_burst(4'b0001, 32'd255, 255, 0, win);
    chk("ones_src255", burst_ones, 255);

    // Short bursts: both give 1,0,1,0 whether or not cnt restarts
    run_burst(4'b0001, 32'd128, 3, 0, win);
    chk("short1_bits", int'(obs_bits[3:0]), 4'b1010);
    run_burst(4'b0001, 32'd128, 3, 0, win);
    chk("short2_bits", int'(obs_bits[3:0]), 4'b1010);

    // Backpressure: 5 stalled cycles mid-burst
    start_burst(4'b0010, 32'h0000_5A00, 20, win);
    begin
      int t;
      t = 0;
      while (burst_bits < 7 && t < 200) begin
        @(negedge clk);
        t++;
      end
    end
    stall = 1;
    hold_bit = out_bit;
    hold_bits = burst_bits;
    repeat (5) begin
      @(negedge clk);
      chk("stall_bit", int'(out_bit), int'(hold_bit));
      chk("stall_valid", int'(out_valid), 1);
    end
    chk("stall_count", burst_bits, hold_bits);
    stall = 0;
    finish_burst(20, 0);

    // Round-robin order from a fresh pointer
    do_reset();
    rdy_rand = 1;
    for (int k = 0; k < 5; k++) begin
      rnd = $urandom;
      run_burst(4'b1111, rnd, $urandom_range(5), 0, win);
      chk("rr_1111", win, rr_a[k]);
    end
    for (int k = 0; k < 3; k++) begin
      rnd = $urandom;
      run_burst(4'b1010, rnd, $urandom_range(5), 0, win);
      chk("rr_1010", win, rr_b[k]);
    end

    // Reset at bit 10 of a burst
    rdy_rand = 0;
    rnd = $urandom;
    start_burst(4'b0001, rnd, 30, win);
    begin
      int t;
      t = 0;
      while (burst_bits < 10 && t < 200) begin
        @(negedge clk);
        t++;
      end
    end
    rst = 1'b0;
    req = 4'd0;
    q.delete();
    pend_done = 0;
    m_cnt = 0;
    m_ptr = 0;
    #1;
    chk("midrst_gnt", int'(gnt), 0);
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("no_done_after_rst", int'(done), 0);
    end
    run_burst(4'b0100, 32'h0001_0000, 3, 0, win);
    chk("post_rst_winner", win, 2);
    chk("post_rst_bits", int'(obs_bits[3:0]), 4'b1000);

    // Random bursts with inputs scrambled during RUN
    rdy_rand = 1;
    for (int k = 0; k < 25; k++) begin
      rnd = $urandom;
      run_burst(4'($urandom_range(15, 1)), rnd, $urandom_range(20), 1, win);
    end
    req = 4'd0;
    rdy_rand = 0;

    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
